// File: rtl/poly_phase_accum.sv
// Time-multiplexed multi-voice phase accumulator: one phase sample per voice,
// emitted round-robin over a valid/ready stream with per-voice note control.
module poly_phase_accum #(
    parameter int unsigned  PHASE_W    = 24,
    parameter int unsigned  NUM_VOICES = 4,
    parameter int unsigned  RETRIGGER  = 0,
    localparam int unsigned VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fcw_wr_en,
    input  logic [VOICE_W-1:0]    fcw_wr_voice,
    input  logic [PHASE_W-1:0]    fcw_wr_data,
    input  logic [NUM_VOICES-1:0] note_start,
    input  logic [NUM_VOICES-1:0] note_release,
    input  logic [NUM_VOICES-1:0] note_reset,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [PHASE_W-1:0]    out_phase,
    output logic [VOICE_W-1:0]    out_voice,
    output logic                  out_active,
    output logic                  out_frame_start,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic [NUM_VOICES-1:0] note_finished
);

    logic [PHASE_W-1:0]    acc_q [NUM_VOICES];
    logic [PHASE_W-1:0]    acc_d [NUM_VOICES];
    logic [PHASE_W-1:0]    fcw_q [NUM_VOICES];
    logic [PHASE_W-1:0]    fcw_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_q;
    logic [NUM_VOICES-1:0] active_d;
    logic [VOICE_W-1:0]    ptr_q;
    logic [VOICE_W-1:0]    ptr_d;
    logic [NUM_VOICES-1:0] fin_q;
    logic [NUM_VOICES-1:0] fin_d;

    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [PHASE_W-1:0]    out_phase_q;
    logic [PHASE_W-1:0]    out_phase_d;
    logic [VOICE_W-1:0]    out_voice_q;
    logic [VOICE_W-1:0]    out_voice_d;
    logic                  out_active_q;
    logic                  out_active_d;
    logic                  out_fs_q;
    logic                  out_fs_d;

    logic                  load_c;
    logic [PHASE_W-1:0]    slot_acc_c;
    logic                  slot_active_c;

    // Output slice accepts a new slot when empty or being drained.
    assign load_c = !out_valid_q || out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v] <= '0;
                fcw_q[v] <= '0;
            end
            active_q     <= '0;
            ptr_q        <= '0;
            fin_q        <= '0;
            out_valid_q  <= 1'b0;
            out_phase_q  <= '0;
            out_voice_q  <= '0;
            out_active_q <= 1'b0;
            out_fs_q     <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v] <= acc_d[v];
                fcw_q[v] <= fcw_d[v];
            end
            active_q     <= active_d;
            ptr_q        <= ptr_d;
            fin_q        <= fin_d;
            out_valid_q  <= out_valid_d;
            out_phase_q  <= out_phase_d;
            out_voice_q  <= out_voice_d;
            out_active_q <= out_active_d;
            out_fs_q     <= out_fs_d;
        end
    end

    // Next state: per-voice IDLE/ACTIVE machine, accumulator step, FCW writes, slot pointer.
    always_comb begin
        active_d = active_q;
        ptr_d    = ptr_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            acc_d[v] = acc_q[v];
            fcw_d[v] = fcw_q[v];
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (note_reset[v]) begin
                active_d[v] = 1'b0;
                acc_d[v]    = '0;
            end else if (note_release[v] && active_q[v]) begin
                active_d[v] = 1'b0;
            end else if (note_start[v] && (!active_q[v] || (RETRIGGER != 0))) begin
                active_d[v] = 1'b1;
                acc_d[v]    = '0;
            end else if (load_c && active_q[v] && (ptr_q == VOICE_W'(v))) begin
                // Increment uses the FCW held before any same-cycle write.
                acc_d[v] = acc_q[v] + fcw_q[v];
            end

            // Out-of-range voice indices never match, so such writes are dropped.
            if (fcw_wr_en && (fcw_wr_voice == VOICE_W'(v))) begin
                fcw_d[v] = fcw_wr_data;
            end
        end

        if (load_c) begin
            ptr_d = (ptr_q == VOICE_W'(NUM_VOICES - 1)) ? '0 : ptr_q + VOICE_W'(1);
        end
    end

    // Output next values: slot sample from pre-edge state and release pulses.
    always_comb begin
        slot_acc_c    = '0;
        slot_active_c = 1'b0;
        out_valid_d   = out_valid_q;
        out_phase_d   = out_phase_q;
        out_voice_d   = out_voice_q;
        out_active_d  = out_active_q;
        out_fs_d      = out_fs_q;
        fin_d         = '0;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (ptr_q == VOICE_W'(v)) begin
                slot_acc_c    = acc_q[v];
                slot_active_c = active_q[v];
            end
            fin_d[v] = note_release[v] && active_q[v] && !note_reset[v];
        end

        if (load_c) begin
            out_valid_d  = 1'b1;
            out_phase_d  = slot_active_c ? slot_acc_c : '0;
            out_voice_d  = ptr_q;
            out_active_d = slot_active_c;
            out_fs_d     = (ptr_q == '0);
        end
    end

    assign out_valid       = out_valid_q;
    assign out_phase       = out_phase_q;
    assign out_voice       = out_voice_q;
    assign out_active      = out_active_q;
    assign out_frame_start = out_fs_q;
    assign voice_active    = active_q;
    assign note_finished   = fin_q;

endmodule

// File: tb/tb_poly_phase_accum.sv
// Self-checking bench for poly_phase_accum: constant vector table, hand-built
// corner sequences, and randomized traffic against a behavioural model.
module tb_poly_phase_accum;

    localparam int unsigned PW = 24;
    localparam int unsigned NV = 4;
    localparam int unsigned VW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fcw_wr_en;
    logic [VW-1:0] fcw_wr_voice;
    logic [PW-1:0] fcw_wr_data;
    logic [NV-1:0] note_start;
    logic [NV-1:0] note_release;
    logic [NV-1:0] note_reset;
    logic          out_ready;

    logic          o_valid  [2];
    logic [PW-1:0] o_phase  [2];
    logic [VW-1:0] o_voice  [2];
    logic          o_active [2];
    logic          o_fs     [2];
    logic [NV-1:0] o_vact   [2];
    logic [NV-1:0] o_fin    [2];

    always #5 clk = ~clk;

    poly_phase_accum #(.PHASE_W(PW), .NUM_VOICES(NV), .RETRIGGER(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .fcw_wr_en(fcw_wr_en), .fcw_wr_voice(fcw_wr_voice), .fcw_wr_data(fcw_wr_data),
        .note_start(note_start), .note_release(note_release), .note_reset(note_reset),
        .out_ready(out_ready), .out_valid(o_valid[0]), .out_phase(o_phase[0]),
        .out_voice(o_voice[0]), .out_active(o_active[0]), .out_frame_start(o_fs[0]),
        .voice_active(o_vact[0]), .note_finished(o_fin[0])
    );

    poly_phase_accum #(.PHASE_W(PW), .NUM_VOICES(NV), .RETRIGGER(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .fcw_wr_en(fcw_wr_en), .fcw_wr_voice(fcw_wr_voice), .fcw_wr_data(fcw_wr_data),
        .note_start(note_start), .note_release(note_release), .note_reset(note_reset),
        .out_ready(out_ready), .out_valid(o_valid[1]), .out_phase(o_phase[1]),
        .out_voice(o_voice[1]), .out_active(o_active[1]), .out_frame_start(o_fs[1]),
        .voice_active(o_vact[1]), .note_finished(o_fin[1])
    );

    // Behavioural model, one copy per RETRIGGER setting (index = RETRIGGER).
    int unsigned m_acc [2][NV];
    int unsigned m_fcw [2][NV];
    bit          m_act [2][NV];
    bit          m_fin [2][NV];
    int unsigned m_ptr [2];
    bit          m_ov  [2];
    int unsigned m_ph  [2];
    int unsigned m_vo  [2];
    bit          m_oa  [2];
    bit          m_fs  [2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic          fcw_en;
        logic [VW-1:0] fcw_v;
        logic [PW-1:0] fcw_d;
        logic [NV-1:0] start;
        logic [VW-1:0] e_voice;
        logic [PW-1:0] e_phase;
        logic          e_active;
        logic          e_fs;
        logic [NV-1:0] e_vact;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < NV; v++) begin
                m_acc[r][v] = 0; m_fcw[r][v] = 0; m_act[r][v] = 0; m_fin[r][v] = 0;
            end
            m_ptr[r] = 0; m_ov[r] = 0; m_ph[r] = 0; m_vo[r] = 0; m_oa[r] = 0; m_fs[r] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int r = 0; r < 2; r++) begin
            bit          ld;
            int unsigned p;
            int unsigned sp;
            bit          sa;
            ld = !m_ov[r] || out_ready;
            p  = m_ptr[r];
            sa = m_act[r][p];
            sp = sa ? m_acc[r][p] : 0;
            for (int v = 0; v < NV; v++) begin
                m_fin[r][v] = 0;
                if (note_reset[v]) begin
                    m_act[r][v] = 0;
                    m_acc[r][v] = 0;
                end else if (note_release[v] && m_act[r][v]) begin
                    m_act[r][v] = 0;
                    m_fin[r][v] = 1;
                end else if (note_start[v] && (!m_act[r][v] || r == 1)) begin
                    m_act[r][v] = 1;
                    m_acc[r][v] = 0;
                end else if (ld && v == p && m_act[r][v]) begin
                    m_acc[r][v] = (m_acc[r][v] + m_fcw[r][v]) % 32'h0100_0000;
                end
            end
            if (fcw_wr_en && int'(fcw_wr_voice) < NV) m_fcw[r][fcw_wr_voice] = fcw_wr_data;
            if (ld) begin
                m_ov[r] = 1; m_ph[r] = sp; m_vo[r] = p; m_oa[r] = sa; m_fs[r] = (p == 0);
                m_ptr[r] = (p + 1) % NV;
            end
        end
    endtask

    function automatic logic [NV-1:0] m_act_vec(input int r);
        logic [NV-1:0] x;
        for (int v = 0; v < NV; v++) x[v] = m_act[r][v];
        return x;
    endfunction

    function automatic logic [NV-1:0] m_fin_vec(input int r);
        logic [NV-1:0] x;
        for (int v = 0; v < NV; v++) x[v] = m_fin[r][v];
        return x;
    endfunction

    task automatic compare_all(input string tag);
        for (int r = 0; r < 2; r++) begin
            check($sformatf("%s r%0d out_valid", tag, r), o_valid[r], m_ov[r]);
            check($sformatf("%s r%0d out_phase", tag, r), o_phase[r], m_ph[r]);
            check($sformatf("%s r%0d out_voice", tag, r), o_voice[r], m_vo[r]);
            check($sformatf("%s r%0d out_active", tag, r), o_active[r], m_oa[r]);
            check($sformatf("%s r%0d out_frame_start", tag, r), o_fs[r], m_fs[r]);
            check($sformatf("%s r%0d voice_active", tag, r), o_vact[r], m_act_vec(r));
            check($sformatf("%s r%0d note_finished", tag, r), o_fin[r], m_fin_vec(r));
        end
    endtask

    task automatic clear_pulses();
        fcw_wr_en = 0; fcw_wr_voice = '0; fcw_wr_data = '0;
        note_start = '0; note_release = '0; note_reset = '0;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
        clear_pulses();
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_pulses();
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        #1;
        compare_all("reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic step_to_slot(input int unsigned v, input string tag);
        bit found = 0;
        for (int i = 0; i < 2 * NV && !found; i++) begin
            step(tag);
            if (m_ov[0] && m_vo[0] == v) found = 1;
        end
        check($sformatf("%s slot %0d reached", tag, v), found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        clear_pulses();

        for (int k = 0; k < 18; k++) begin
            vecs[k].fcw_en   = 1'b0;
            vecs[k].fcw_v    = '0;
            vecs[k].fcw_d    = '0;
            vecs[k].start    = '0;
            vecs[k].e_voice  = VW'(k % 4);
            vecs[k].e_phase  = '0;
            vecs[k].e_active = 1'b0;
            vecs[k].e_fs     = (k % 4 == 0);
            vecs[k].e_vact   = (k >= 6) ? 4'b0010 : 4'b0000;
        end
        vecs[5].fcw_en   = 1'b1;
        vecs[5].fcw_v    = 2'd1;
        vecs[5].fcw_d    = 24'h000100;
        vecs[6].start    = 4'b0010;
        vecs[9].e_active = 1'b1;
        vecs[13].e_active = 1'b1;
        vecs[13].e_phase  = 24'h000100;
        vecs[17].e_active = 1'b1;
        vecs[17].e_phase  = 24'h000200;

        do_reset();

        // Idle round-robin, then voice 1 stepping by 0x100.
        for (int k = 0; k < 18; k++) begin
            out_ready    = 1'b1;
            fcw_wr_en    = vecs[k].fcw_en;
            fcw_wr_voice = vecs[k].fcw_v;
            fcw_wr_data  = vecs[k].fcw_d;
            note_start   = vecs[k].start;
            step("vec");
            for (int r = 0; r < 2; r++) begin
                check($sformatf("vec%0d r%0d valid", k, r), o_valid[r], 1);
                check($sformatf("vec%0d r%0d voice", k, r), o_voice[r], vecs[k].e_voice);
                check($sformatf("vec%0d r%0d phase", k, r), o_phase[r], vecs[k].e_phase);
                check($sformatf("vec%0d r%0d active", k, r), o_active[r], vecs[k].e_active);
                check($sformatf("vec%0d r%0d fs", k, r), o_fs[r], vecs[k].e_fs);
                check($sformatf("vec%0d r%0d vact", k, r), o_vact[r], vecs[k].e_vact);
            end
        end

        // Wrap modulo 2^24 on voice 0.
        do_reset();
        out_ready = 1'b1;
        fcw_wr_en = 1'b1; fcw_wr_voice = 2'd0; fcw_wr_data = 24'hFFFFFF; note_start = 4'b0001;
        step("wrap");
        step_to_slot(0, "wrap");
        check("wrap phase0", o_phase[0], 24'h000000);
        check("wrap active0", o_active[0], 1);
        step_to_slot(0, "wrap");
        check("wrap phase1", o_phase[0], 24'hFFFFFF);
        step_to_slot(0, "wrap");
        check("wrap phase2", o_phase[0], 24'hFFFFFE);

        // Backpressure on voice 2, with an FCW write landing during the stall.
        do_reset();
        out_ready = 1'b1;
        fcw_wr_en = 1'b1; fcw_wr_voice = 2'd2; fcw_wr_data = 24'h000010; note_start = 4'b0100;
        step("stall");
        step_to_slot(2, "stall");
        check("stall first phase", o_phase[0], 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                fcw_wr_en = 1'b1; fcw_wr_voice = 2'd2; fcw_wr_data = 24'h000020;
            end
            step("stall_hold");
            check($sformatf("stall%0d voice", i), o_voice[0], 2);
            check($sformatf("stall%0d valid", i), o_valid[0], 1);
            check($sformatf("stall%0d active", i), o_active[0], 1);
        end
        out_ready = 1'b1;
        step("stall_resume");
        check("resume voice", o_voice[0], 3);
        step_to_slot(2, "stall");
        check("stall acc held", o_phase[0], 24'h000010);
        step_to_slot(2, "stall");
        check("stall new fcw", o_phase[0], 24'h000030);

        // Release pulse, then release+reset collision.
        do_reset();
        out_ready = 1'b1;
        fcw_wr_en = 1'b1; fcw_wr_voice = 2'd3; fcw_wr_data = 24'h000005; note_start = 4'b1000;
        step("rel");
        step_to_slot(3, "rel");
        check("rel active slot", o_active[0], 1);
        note_release = 4'b1000;
        step("rel");
        check("rel fin pulse", o_fin[0], 4'b1000);
        check("rel vact", o_vact[0], 4'b0000);
        step("rel");
        check("rel fin clear", o_fin[0], 4'b0000);
        step_to_slot(3, "rel");
        check("rel idle active", o_active[0], 0);
        check("rel idle phase", o_phase[0], 0);
        note_start = 4'b0010;
        step("relrst");
        note_release = 4'b0010; note_reset = 4'b0010;
        step("relrst");
        check("relrst no pulse", o_fin[0], 4'b0000);
        check("relrst vact", o_vact[0], 4'b0000);

        // Start on an already-active voice: ignored vs retriggered.
        do_reset();
        out_ready = 1'b1;
        fcw_wr_en = 1'b1; fcw_wr_voice = 2'd1; fcw_wr_data = 24'h000100; note_start = 4'b0010;
        step("retrig");
        for (int i = 0; i < 4; i++) step_to_slot(1, "retrig");
        check("retrig r0 pre", o_phase[0], 24'h000300);
        check("retrig r1 pre", o_phase[1], 24'h000300);
        note_start = 4'b0010;
        step("retrig");
        step_to_slot(1, "retrig");
        check("retrig r0 ignored", o_phase[0], 24'h000400);
        check("retrig r1 restart", o_phase[1], 24'h000000);

        // Randomized traffic with a mid-stream reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            fcw_wr_en    = ($urandom_range(0, 7) == 0);
            fcw_wr_voice = VW'($urandom_range(0, NV - 1));
            fcw_wr_data  = PW'($urandom);
            for (int v = 0; v < NV; v++) begin
                note_start[v]   = ($urandom_range(0, 19) == 0);
                note_release[v] = ($urandom_range(0, 29) == 0);
                note_reset[v]   = ($urandom_range(0, 59) == 0);
            end
            step("rand");
            if (i == 300) begin
                do_reset();
                out_ready = 1'b1;
                step("post_reset");
                check("post_reset voice", o_voice[0], 0);
                check("post_reset fs", o_fs[0], 1);
                check("post_reset active", o_active[0], 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_phase_accum.md
Name: poly_phase_accum

Overview:
- Time-multiplexed, multi-voice phase accumulator; next generation of the single-voice phase accumulator in the audio path.
- Holds NUM_VOICES independent accumulators, each with its own FCW and note state.
- Emits one phase sample per voice in a fixed round-robin frame over a valid/ready stream.
- Feeds the wave-table lookup and the mixer.

Parameters:
- PHASE_W, 24, accumulator and FCW width; the accumulator wraps modulo 2^PHASE_W.
- NUM_VOICES, 4, number of voices, 2..16.
- VOICE_W, $clog2(NUM_VOICES), voice index width (derived localparam; not overridden).
- RETRIGGER, 0, 1 means note_start on an active voice restarts it; 0 means it is ignored.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fcw_wr_en, input, 1, writes fcw_wr_data into the FCW register of voice fcw_wr_voice.
- fcw_wr_voice, input, VOICE_W, FCW write target; writes with an index >= NUM_VOICES are dropped.
- fcw_wr_data, input, PHASE_W, new FCW value.
- note_start, input, NUM_VOICES, per-voice single-cycle start pulses.
- note_release, input, NUM_VOICES, per-voice single-cycle release pulses.
- note_reset, input, NUM_VOICES, per-voice single-cycle reset pulses.
- out_ready, input, 1, downstream can accept a sample.
- out_valid, output, 1, output sample valid.
- out_phase, output, PHASE_W, phase of the voice in the current slot (0 if that voice is idle).
- out_voice, output, VOICE_W, voice index of the current slot.
- out_active, output, 1, voice in the current slot was active.
- out_frame_start, output, 1, high when out_voice == 0.
- voice_active, output, NUM_VOICES, live per-voice active flags.
- note_finished, output, NUM_VOICES, one-cycle pulse per voice on release.

Behaviour:
- Reset, asynchronous and active-low:
  - All accumulators and FCWs are 0; all voices are IDLE; the slot pointer is 0.
  - out_valid, out_phase, out_voice, out_active, out_frame_start, voice_active and note_finished are all 0.
- Per-voice state machine has two states, IDLE and ACTIVE:
  - IDLE + note_start: go to ACTIVE and clear the accumulator to 0.
  - ACTIVE + note_start: if RETRIGGER=1, clear the accumulator to 0 and stay ACTIVE; otherwise ignore.
  - ACTIVE + note_release: go to IDLE, hold the accumulator value, and pulse note_finished[v] on the next cycle.
  - IDLE + note_release: no effect, no pulse.
  - note_reset in any state: go to IDLE, clear the accumulator, and produce no note_finished pulse.
  - Priority within one voice, highest first: note_reset, then note_release, then note_start.
  - Events on different voices in the same cycle are independent.
- Output stage is a single register slice with load condition L = !out_valid || out_ready.
  - On L, the slot for voice p = pointer is loaded from pre-edge state:
    - out_phase = acc[p] if active, else 0.
    - out_active = active[p].
    - out_voice = p.
    - out_frame_start = (p == 0).
    - out_valid = 1.
  - The pointer then advances to p+1, wrapping from NUM_VOICES-1 to 0.
  - On L with voice p active and no note event on p this cycle: acc[p] <= acc[p] + fcw[p] (old FCW), truncated to PHASE_W bits.
  - A note event on voice p overrides the increment; the loaded slot still shows pre-event values.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals hold, the pointer holds, and no accumulator increments.
  - Note events and FCW writes are still applied while stalled.
- Latency:
  - The first sample (voice 0) appears on the first rising edge after rst_n deasserts.
  - With out_ready held high: one sample per cycle and one full frame every NUM_VOICES cycles.
  - Each active voice advances exactly once per frame.
- FCW write to voice p in the same cycle that slot p loads: the increment uses the old FCW and the new value is stored.
- Reset asserted mid-stream clears everything immediately; no partial frame resumes afterwards.

Test Plan:
- Reset, then out_ready=1 and no notes -> out_voice cycles 0,1,2,3,0; out_phase=0; out_active=0; out_frame_start high on every voice-0 slot.
- FCW[1]=0x000100, start voice 1 -> voice-1 slots show 0x000000, 0x000100, 0x000200, ...; other voices stay 0/inactive.
- FCW[0]=0xFFFFFF, start voice 0 -> voice-0 slots show 0x000000, 0xFFFFFF, 0xFFFFFE (wrap modulo 2^24).
- Active voice 2 with out_ready low for 5 cycles -> all outputs held and acc[2] unchanged; on release of the stall the stream resumes at the held slot.
- Release of active voice 3 -> note_finished[3] pulses for exactly 1 cycle and the next voice-3 slot shows out_active=0, out_phase=0; release and reset in the same cycle -> reset wins and there is no pulse.
- RETRIGGER=0 vs 1, start on active voice 1 at phase 0x000300 -> with 0 the next slot shows 0x000400; with 1 the slot after the event shows 0x000000.
